lru_tag_lookup: RTL and testbench

- Fully associative tag directory that sits directly upstream of the counter-based LRU tracker.
- Each lookup request compares its tag against NO_ENTRY stored tags and returns hit or miss plus the entry index.
- On a miss it allocates an entry: the lowest free entry if one exists, otherwise the LRU victim.
- Every completed lookup drives a one-cycle access pulse (acc_en/acc_idx) into the LRU tracker and consumes the tracker's lru_idx.

---
 rtl/lru_tag_lookup.sv | 195 +++++++++++++++++++
 tb/tb_lru_tag_lookup.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lru_tag_lookup.sv
// lru_tag_lookup: fully associative tag directory in front of a counter-based LRU tracker.
// Each request is compared against all stored tags. A miss allocates the lowest free entry,
// or the tracker's LRU entry when the directory is full. Every lookup emits a one-cycle
// access pulse (acc_en/acc_idx) so the tracker updates on the same edge.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   flush               invalidate all entries (honoured only while idle)
//   req_valid/ready/tag lookup request handshake and tag
//   rsp_valid/ready     response handshake
//   rsp_hit/idx         hit flag and entry index (hit or allocated)
//   rsp_evict/evict_tag valid entry replaced, and its old tag (0 otherwise)
//   acc_en/acc_idx      access pulse to the LRU tracker
//   lru_idx             current LRU entry from the tracker
//   hit_cnt/miss_cnt    saturating lookup counters, only with LRU_TAG_STATS_EN defined
//
// Optional feature macro: LRU_TAG_STATS_EN

`timescale 1ns/1ps

module lru_tag_lookup #(
  parameter int unsigned NO_ENTRY  = 8,
  parameter int unsigned IDX_WIDTH = $clog2(NO_ENTRY),
  parameter int unsigned TAG_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_hit,
  output logic [IDX_WIDTH-1:0] rsp_idx,
  output logic                 rsp_evict,
  output logic [TAG_WIDTH-1:0] rsp_evict_tag,
  output logic                 acc_en,
  output logic [IDX_WIDTH-1:0] acc_idx,
`ifdef LRU_TAG_STATS_EN
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt,
`endif
  input  logic [IDX_WIDTH-1:0] lru_idx
);

  typedef enum logic [1:0] {StIdle, StLookup, StResp} state_e;

  state_e r_state, w_state_next;

  logic [NO_ENTRY-1:0]  r_valid;
  logic [TAG_WIDTH-1:0] r_tag [NO_ENTRY];
  logic [TAG_WIDTH-1:0] r_req_tag;
  logic                 r_rsp_hit;
  logic [IDX_WIDTH-1:0] r_rsp_idx;
  logic                 r_rsp_evict;
  logic [TAG_WIDTH-1:0] r_rsp_evict_tag;

  logic [NO_ENTRY-1:0]  w_match;
  logic                 w_hit;
  logic [IDX_WIDTH-1:0] w_hit_idx;
  logic                 w_free;
  logic [IDX_WIDTH-1:0] w_free_idx;
  logic [IDX_WIDTH-1:0] w_idx;
  logic                 w_evict;

  // Tag compare and lowest-index priority encoders. Scanning downward lets the
  // lowest index win, which also resolves illegal multiple hits.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = 0; i < int'(NO_ENTRY); i++) begin
      w_match[i] = r_valid[i] && (r_tag[i] == r_req_tag);
    end
    for (int i = int'(NO_ENTRY) - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_WIDTH'(i);
      end
      if (!r_valid[i]) begin
        w_free     = 1'b1;
        w_free_idx = IDX_WIDTH'(i);
      end
    end
    w_evict = !w_hit && !w_free;
    if (w_hit) begin
      w_idx = w_hit_idx;
    end else if (w_free) begin
      w_idx = w_free_idx;
    end else begin
      w_idx = lru_idx;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (!flush && req_valid) begin
          w_state_next = StLookup;
        end
      end
      StLookup: w_state_next = StResp;
      StResp: begin
        if (rsp_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready     = (r_state == StIdle) && !flush;
    acc_en        = (r_state == StLookup);
    acc_idx       = (r_state == StLookup) ? w_idx : '0;
    rsp_valid     = (r_state == StResp);
    rsp_hit       = r_rsp_hit;
    rsp_idx       = r_rsp_idx;
    rsp_evict     = r_rsp_evict;
    rsp_evict_tag = r_rsp_evict_tag;
  end

  // Directory and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid         <= '0;
      r_req_tag       <= '0;
      r_rsp_hit       <= 1'b0;
      r_rsp_idx       <= '0;
      r_rsp_evict     <= 1'b0;
      r_rsp_evict_tag <= '0;
      for (int i = 0; i < int'(NO_ENTRY); i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (flush) begin
            r_valid <= '0;
          end else if (req_valid) begin
            r_req_tag <= req_tag;
          end
        end
        StLookup: begin
          r_rsp_hit       <= w_hit;
          r_rsp_idx       <= w_idx;
          r_rsp_evict     <= w_evict;
          r_rsp_evict_tag <= w_evict ? r_tag[w_idx] : '0;
          if (!w_hit) begin
            r_tag[w_idx]   <= r_req_tag;
            r_valid[w_idx] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LRU_TAG_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == StLookup) begin
      if (w_hit && (r_hit_cnt != 32'hFFFF_FFFF)) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (!w_hit && (r_miss_cnt != 32'hFFFF_FFFF)) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_lru_tag_lookup.sv
`timescale 1ns/1ps

module tb_lru_tag_lookup;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [19:0] req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_hit;
  logic [2:0]  rsp_idx;
  logic        rsp_evict;
  logic [19:0] rsp_evict_tag;
  logic        acc_en;
  logic [2:0]  acc_idx;
  logic [2:0]  lru_idx;
`ifdef LRU_TAG_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  lru_tag_lookup #(
    .NO_ENTRY (8),
    .TAG_WIDTH(20)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_tag      (req_tag),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_hit      (rsp_hit),
    .rsp_idx      (rsp_idx),
    .rsp_evict    (rsp_evict),
    .rsp_evict_tag(rsp_evict_tag),
    .acc_en       (acc_en),
    .acc_idx      (acc_idx),
`ifdef LRU_TAG_STATS_EN
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt),
`endif
    .lru_idx      (lru_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // LRU tracker model: recency list, oldest at position 0.
  int ord [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
  assign lru_idx = 3'(ord[0]);

  always @(posedge clk) begin
    int tmp [8];
    int p;
    if (acc_en) begin
      tmp = ord;
      p = 0;
      for (int i = 0; i < 8; i++) if (tmp[i] == int'(acc_idx)) p = i;
      for (int i = p; i < 7; i++) tmp[i] = tmp[i + 1];
      tmp[7] = int'(acc_idx);
      ord <= tmp;
    end
  end

  typedef struct {
    logic        hit;
    logic [2:0]  idx;
    logic        evict;
    logic [19:0] etag;
  } exp_t;

  exp_t sb [$];
  int   acc_q [$];
  logic acc_prev = 1'b0;

  // Monitor: checks access pulses and pops responses on handshake.
  always @(negedge clk) begin
    exp_t e;
    int   ai;
    if (acc_prev) chk("acc_before_rsp", 32'(rsp_valid), 32'd1);
    if (acc_en) begin
      chk("rsp_low_during_acc", 32'(rsp_valid), 32'd0);
      if (acc_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_acc: got acc_idx %0d expected no pulse", acc_idx);
      end else begin
        ai = acc_q.pop_front();
        chk("acc_idx", 32'(acc_idx), 32'(ai));
      end
    end
    acc_prev = acc_en;
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rsp: got idx %0d expected no response", rsp_idx);
      end else begin
        e = sb.pop_front();
        chk("rsp_hit", 32'(rsp_hit), 32'(e.hit));
        chk("rsp_idx", 32'(rsp_idx), 32'(e.idx));
        chk("rsp_evict", 32'(rsp_evict), 32'(e.evict));
        chk("rsp_evict_tag", 32'(rsp_evict_tag), 32'(e.etag));
      end
    end
  end

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready && !rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_rsp_valid();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    chk("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic issue(input logic [19:0] t, input logic h, input logic [2:0] i,
                       input logic e, input logic [19:0] et);
    sb.push_back('{hit: h, idx: i, evict: e, etag: et});
    acc_q.push_back(int'(i));
    @(posedge clk);
    #1 req_valid = 1'b1;
    req_tag = t;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic do_req(input logic [19:0] t, input logic h, input logic [2:0] i,
                        input logic e, input logic [19:0] et);
    issue(t, h, i, e, et);
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    req_valid = 1'b0;
    req_tag = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_acc_en", 32'(acc_en), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_idx", 32'(rsp_idx), 32'd0);
    chk("rst_rsp_evict_tag", 32'(rsp_evict_tag), 32'd0);
`ifdef LRU_TAG_STATS_EN
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
`endif

    // Fill: 0x10..0x17 allocate entries 0..7.
    for (int i = 0; i < 8; i++) do_req(20'h10 + 20'(i), 1'b0, 3'(i), 1'b0, 20'h0);

    do_req(20'h13, 1'b1, 3'd3, 1'b0, 20'h0);
    do_req(20'h10, 1'b1, 3'd0, 1'b0, 20'h0);
    // Recency after accesses 0..7,3,0: LRU is entry 1 holding 0x11.
    do_req(20'h20, 1'b0, 3'd1, 1'b1, 20'h11);

    // 0x11 was evicted; LRU is now entry 2 (0x12). Response is backpressured.
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    issue(20'h11, 1'b0, 3'd2, 1'b1, 20'h12);
    wait_rsp_valid();
    repeat (5) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_idx", 32'(rsp_idx), 32'd2);
      chk("bp_rsp_evict_tag", 32'(rsp_evict_tag), 32'h12);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_acc_en", 32'(acc_en), 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_idle", 32'(req_ready), 32'd1);
    chk("bp_release_rsp_valid", 32'(rsp_valid), 32'd0);

    // Flush with a simultaneous request: request dropped, entries cleared.
    @(posedge clk);
    #1 flush = 1'b1;
    req_valid = 1'b1;
    req_tag = 20'h13;
    @(negedge clk);
    chk("flush_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("flush_no_acc", 32'(acc_en), 32'd0);
    chk("flush_still_idle", 32'(req_ready), 32'd1);
    do_req(20'h20, 1'b0, 3'd0, 1'b0, 20'h0);
    do_req(20'h13, 1'b0, 3'd1, 1'b0, 20'h0);

    // Reset during RESP: the response is dropped.
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    acc_q.push_back(0);
    @(posedge clk);
    #1 req_valid = 1'b1;
    req_tag = 20'h20;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp_valid();
    chk("pre_rst_rsp_hit", 32'(rsp_hit), 32'd1);
`ifdef LRU_TAG_STATS_EN
    chk("pre_rst_hit_cnt", hit_cnt, 32'd3);
    chk("pre_rst_miss_cnt", miss_cnt, 32'd12);
`endif
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
`ifdef LRU_TAG_STATS_EN
    chk("post_rst_hit_cnt", hit_cnt, 32'd0);
    chk("post_rst_miss_cnt", miss_cnt, 32'd0);
`endif
    do_req(20'h13, 1'b0, 3'd0, 1'b0, 20'h0);
    do_req(20'h20, 1'b0, 3'd1, 1'b0, 20'h0);

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("acc_drained", 32'(acc_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
